// File: rtl/rr_index_encoder_if.sv
// Request/grant bundle for rr_index_encoder: multi-hot request pulses in,
// one binary index per valid/ready transaction out.
interface rr_index_encoder_if #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
);
    logic [N-1:0] req;
    logic         clr_ovf;
    logic         ready;
    logic         valid;
    logic [W-1:0] idx;
    logic [N-1:0] pending;
    logic         ovf;

    // Producer/consumer side drives requests and accepts indices.
    modport master (
        output req, clr_ovf, ready,
        input  valid, idx, pending, ovf
    );

    modport slave (
        input  req, clr_ovf, ready,
        output valid, idx, pending, ovf
    );
endinterface

// File: rtl/rr_index_encoder.sv
// Collects multi-hot request pulses into a pending set and hands them out one
// at a time as binary indices, round-robin, over a valid/ready handshake.
module rr_index_encoder #(
    parameter int unsigned N = 8,
    parameter int unsigned W = 3
) (
    input logic              clk,
    input logic              reset_n,
    rr_index_encoder_if.slave bus
);
    logic [N-1:0] pend_q, pend_d;
    logic [N-1:0] grant_mask;
    logic [N-1:0] overflow;
    logic [W-1:0] idx_q, idx_d;
    logic [W-1:0] ptr_q, ptr_d;
    logic [W-1:0] sel;
    logic         valid_q, valid_d;
    logic         ovf_q, ovf_d;
    logic         found;
    logic         load;
    logic         grant;

    // Two passes: bits at or above ptr first, then wrap to the low bits.
    always_comb begin
        sel   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(N); i++) begin
            if (!found && pend_q[i] && (i >= int'(ptr_q))) begin
                sel   = W'(i);
                found = 1'b1;
            end
        end
        for (int i = 0; i < int'(N); i++) begin
            if (!found && pend_q[i]) begin
                sel   = W'(i);
                found = 1'b1;
            end
        end
    end

    assign load  = !valid_q || bus.ready;
    assign grant = load && found;

    always_comb begin
        grant_mask = '0;
        for (int i = 0; i < int'(N); i++) begin
            grant_mask[i] = grant && (int'(sel) == i);
        end
    end

    // A bit granted and re-requested on the same edge stays pending.
    assign overflow = bus.req & pend_q & ~grant_mask;

    always_comb begin
        pend_d  = (pend_q & ~grant_mask) | bus.req;
        valid_d = valid_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        if (load) begin
            valid_d = found;
        end
        if (grant) begin
            idx_d = sel;
            ptr_d = (int'(sel) == int'(N) - 1) ? '0 : sel + 1'b1;
        end
        if (|overflow) begin
            ovf_d = 1'b1;
        end else if (bus.clr_ovf) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_q  <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            ptr_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.valid   = valid_q;
    assign bus.idx     = idx_q;
    assign bus.pending = pend_q;
    assign bus.ovf     = ovf_q;
endmodule

// File: tb/tb_rr_index_encoder.sv
// Randomized and directed bench for rr_index_encoder against a cycle-level
// behavioural model of the pending set, handshake and round-robin pointer.
module tb_rr_index_encoder;
    localparam int N = 8;
    localparam int W = 3;

    logic clk;
    logic reset_n;

    rr_index_encoder_if #(.N(N), .W(W)) bus ();

    rr_index_encoder #(.N(N), .W(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference state
    logic [N-1:0] m_pend;
    logic         m_valid;
    int           m_idx;
    int           m_ptr;
    logic         m_ovf;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_idx   = 0;
        m_ptr   = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] rq, input logic rdy, input logic clr);
        int           gsel;
        logic         ld;
        logic         hit;
        logic [N-1:0] np;
        gsel = -1;
        hit  = 1'b0;
        ld   = !m_valid || rdy;
        if (ld) begin
            for (int k = 0; k < N; k++) begin
                int c;
                c = (m_ptr + k) % N;
                if (gsel < 0 && m_pend[c]) gsel = c;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (rq[i] && m_pend[i] && i != gsel) hit = 1'b1;
            np[i] = (m_pend[i] && i != gsel) || rq[i];
        end
        m_pend = np;
        if (ld) begin
            if (gsel >= 0) begin
                m_valid = 1'b1;
                m_idx   = gsel;
                m_ptr   = (gsel + 1) % N;
            end else begin
                m_valid = 1'b0;
            end
        end
        if (hit) m_ovf = 1'b1;
        else if (clr) m_ovf = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".valid"},   32'(bus.valid),   32'(m_valid));
        check({tag, ".idx"},     32'(bus.idx),     32'(m_idx));
        check({tag, ".pending"}, 32'(bus.pending), 32'(m_pend));
        check({tag, ".ovf"},     32'(bus.ovf),     32'(m_ovf));
    endtask

    // Entered just after a falling edge; returns just after the next one.
    task automatic cycle(input logic [N-1:0] rq, input logic rdy, input logic clr,
                         input string tag);
        bus.req     = rq;
        bus.ready   = rdy;
        bus.clr_ovf = clr;
        @(posedge clk);
        model_step(rq, rdy, clr);
        #1;
        compare_all(tag);
        @(negedge clk);
    endtask

    initial begin
        bus.req     = '0;
        bus.ready   = 1'b0;
        bus.clr_ovf = 1'b0;
        reset_n     = 1'b1;
        model_reset();
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        compare_all("reset");

        for (int i = 0; i < 5; i++) cycle('0, 1'b0, 1'b0, "idle");

        // Single request
        cycle(8'h20, 1'b1, 1'b0, "single_req");
        check("single_pending", 32'(bus.pending), 32'h20);
        cycle('0, 1'b1, 1'b0, "single_grant");
        check("single_valid", 32'(bus.valid), 32'd1);
        check("single_idx", 32'(bus.idx), 32'd5);
        cycle('0, 1'b1, 1'b0, "single_done");
        check("single_empty", 32'(bus.valid), 32'd0);

        // Round-robin from ptr = 6
        cycle(8'h41, 1'b1, 1'b0, "rr_req");
        cycle('0, 1'b1, 1'b0, "rr_g0");
        check("rr_first", 32'(bus.idx), 32'd6);
        cycle('0, 1'b1, 1'b0, "rr_g1");
        check("rr_second", 32'(bus.idx), 32'd0);
        cycle('0, 1'b1, 1'b0, "rr_done");
        check("rr_empty", 32'(bus.valid), 32'd0);

        // Backpressure and same-bit re-request
        cycle(8'h0C, 1'b0, 1'b0, "bp_req");
        for (int i = 0; i < 4; i++) begin
            cycle('0, 1'b0, 1'b0, "bp_stall");
            check("bp_idx_held", 32'(bus.idx), 32'd2);
            check("bp_pending", 32'(bus.pending), 32'h08);
        end
        cycle(8'h04, 1'b0, 1'b0, "bp_rereq");
        check("bp_no_ovf", 32'(bus.ovf), 32'd0);
        check("bp_pending_re", 32'(bus.pending), 32'h0C);
        cycle('0, 1'b1, 1'b0, "bp_acc2");
        check("bp_next3", 32'(bus.idx), 32'd3);
        cycle('0, 1'b1, 1'b0, "bp_acc3");
        check("bp_next2", 32'(bus.idx), 32'd2);
        cycle('0, 1'b1, 1'b0, "bp_drain");

        // Overflow with an unrelated bit held in idx
        cycle(8'h02, 1'b0, 1'b0, "ov_hold_req");
        cycle('0, 1'b0, 1'b0, "ov_hold");
        cycle(8'h01, 1'b0, 1'b0, "ov_first");
        cycle(8'h01, 1'b0, 1'b0, "ov_second");
        check("ov_set", 32'(bus.ovf), 32'd1);
        check("ov_pending", 32'(bus.pending), 32'h01);
        cycle('0, 1'b0, 1'b1, "ov_clr");
        check("ov_cleared", 32'(bus.ovf), 32'd0);
        cycle(8'h01, 1'b0, 1'b1, "ov_clr_set");
        check("ov_set_wins", 32'(bus.ovf), 32'd1);
        for (int i = 0; i < 4; i++) cycle('0, 1'b1, 1'b1, "ov_drain");

        // Reset mid-operation
        cycle(8'h01, 1'b0, 1'b0, "mr_pre");
        cycle(8'hF0, 1'b0, 1'b0, "mr_load");
        check("mr_pending", 32'(bus.pending), 32'hF0);
        check("mr_valid", 32'(bus.valid), 32'd1);
        cycle(8'h01, 1'b0, 1'b0, "mr_ovf");
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        compare_all("mr_async");
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        cycle(8'h82, 1'b1, 1'b0, "mr_after_req");
        cycle('0, 1'b1, 1'b0, "mr_after_grant");
        check("mr_ptr0", 32'(bus.idx), 32'd1);
        cycle('0, 1'b1, 1'b0, "mr_after_grant2");

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [N-1:0] rq;
            rq = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
            cycle(rq, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/rr_index_encoder.md
Name: rr_index_encoder

Overview:
- Sequential encoder. It collects multi-hot request pulses into a pending set and hands them out one at a time as binary indices over a valid/ready handshake.
- Selection among pending bits is round-robin.
- It is the reverse of the register-file write decoder: one-hot/multi-hot in, binary index out.
- It sits between datapath event sources and a controller that consumes one register/event index per transaction.

Parameters:
- N, 8, number of request lines; legal range 2..2^W.
- W, 3, index width; must satisfy 2^W >= N.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- req  input  N  request pulses; bit i high for one cycle sets pending[i].
- clr_ovf  input  1  synchronous clear of ovf.
- ready  input  1  consumer accepts idx this cycle when valid is also high.
- valid  output  1  idx holds a granted request.
- idx  output  W  binary index of the granted request.
- pending  output  N  registered pending set, excluding the entry currently held in idx.
- ovf  output  1  sticky flag: a request was dropped because its bit was already pending.

Behaviour:
- Reset (reset_n low, asynchronous) clears:
  - pending = 0, valid = 0, idx = 0, ovf = 0.
  - Round-robin pointer ptr = 0.
- All state is registered; no output is combinational from inputs.
- Load condition: load = !valid || (valid && ready).
- On a clock edge with load:
  - If pending != 0: sel = first set bit of pending, scanning ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Then valid <= 1, idx <= sel, pending[sel] cleared, ptr <= (sel+1 == N) ? 0 : sel+1.
  - If pending == 0: valid <= 0, idx holds its old value, ptr unchanged.
- Without load (valid && !ready): valid, idx and ptr hold. idx is stable under backpressure.
- Request merge, applied every edge: pending_next = (pending & ~grant_mask) | req.
  - grant_mask is the one-hot of sel when a grant occurs, else 0.
- Selection uses only registered pending, so req is never bypassed into the same cycle. Latency when idle: req at edge t -> pending at edge t+1 -> valid/idx at edge t+2.
- Simultaneous set and grant of the same bit: the set wins. The bit remains pending and is granted again later.
- Overflow: req[i] high while pending[i] is high and i is not being granted this edge -> request dropped, ovf <= 1.
- ovf update per edge:
  - clr_ovf and a new overflow on the same edge: ovf <= 1 (set wins).
  - clr_ovf alone: ovf <= 0.
- A request for the index currently held in idx (valid, unaccepted) is not an overflow; it becomes pending.
- Back-to-back throughput: one grant per cycle while ready = 1 and pending != 0.
- Non-power-of-2 N: ptr wraps at N. Indices >= N are never produced.
- Reset mid-transfer: valid drops immediately (asynchronously). All pending requests are lost. ovf clears.

Test Plan:
- Reset then idle: reset_n low 2 cycles, release, req = 0 for 5 cycles -> valid = 0, idx = 0, pending = 0, ovf = 0 throughout.
- Single request: ready = 1, req = 8'h20 for one cycle at edge t -> pending = 8'h20 after t+1; valid = 1, idx = 5 after t+2; valid = 0 after t+3.
- Round-robin: after the idx = 5 grant (ptr = 6), req = 8'h41 pulse -> grants idx = 6 then idx = 0 on consecutive cycles, then valid = 0.
- Backpressure and same-bit re-request:
  - Setup: req = 8'h0C, ready = 0.
  - Expected: idx = 2 held with valid = 1 for 4 cycles, pending = 8'h08.
  - Stimulus: pulse req = 8'h04 during the stall.
  - Expected: no ovf, pending = 8'h0C.
  - Then raise ready -> grants 2, 3, 2 in sequence.
- Overflow:
  - req = 8'h01 with ready = 0 and an unrelated bit already held in idx; pulse req = 8'h01 again -> ovf = 1 and pending = 8'h01.
  - Pulse clr_ovf -> ovf = 0.
  - clr_ovf coincident with a new overflow -> ovf stays 1.
- Reset mid-operation: with pending = 8'hF0 and valid = 1, assert reset_n low between clock edges -> valid, idx, pending, ovf go to 0 without waiting for clk; first grant after release follows ptr = 0.
